// File: rtl/pm_loader.sv
// Byte-stream program-memory loader: parses SYNC/addr/count/words/checksum frames
// and writes 16-bit words into program memory while holding the core stalled.
module pm_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned AW        = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pm_we,
    output logic [AW-1:0] pm_addr,
    output logic [15:0]   pm_din,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        StIdle,
        StAddrL,
        StAddrH,
        StCntL,
        StCntH,
        StDataL,
        StDataH,
        StWrite,
        StCsum
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    addr_lo_q, addr_lo_d;
    logic [7:0]    lo_q, lo_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          pm_we_q, pm_we_d;
    logic [AW-1:0] pm_addr_q, pm_addr_d;
    logic [15:0]   pm_din_q, pm_din_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          xfer;
    logic [15:0]   addr_full;

    // Reset gates the handshake so no byte is consumed during reset.
    assign in_ready  = (state_q != StWrite) && !rst;
    assign xfer      = in_valid && in_ready;
    assign addr_full = {in_data, addr_lo_q};

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        addr_lo_d = addr_lo_q;
        lo_d      = lo_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        pm_we_d   = 1'b0;
        pm_addr_d = pm_addr_q;
        pm_din_d  = pm_din_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    sum_d   = 8'h00;
                    state_d = StAddrL;
                end
            end
            StAddrL: begin
                if (xfer) begin
                    addr_lo_d = in_data;
                    sum_d     = sum_q + in_data;
                    state_d   = StAddrH;
                end
            end
            StAddrH: begin
                // Pointer is loaded here; it is untouched until the data phase.
                if (xfer) begin
                    ptr_d   = addr_full[AW-1:0];
                    sum_d   = sum_q + in_data;
                    state_d = StCntL;
                end
            end
            StCntL: begin
                if (xfer) begin
                    cnt_d[7:0] = in_data;
                    sum_d      = sum_q + in_data;
                    state_d    = StCntH;
                end
            end
            StCntH: begin
                if (xfer) begin
                    cnt_d[15:8] = in_data;
                    sum_d       = sum_q + in_data;
                    state_d     = ({in_data, cnt_q[7:0]} == 16'h0000) ? StCsum : StDataL;
                end
            end
            StDataL: begin
                if (xfer) begin
                    lo_d    = in_data;
                    sum_d   = sum_q + in_data;
                    state_d = StDataH;
                end
            end
            StDataH: begin
                if (xfer) begin
                    sum_d     = sum_q + in_data;
                    pm_we_d   = 1'b1;
                    pm_addr_d = ptr_q;
                    pm_din_d  = {in_data, lo_q};
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                ptr_d   = ptr_q + AW'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? StCsum : StDataL;
            end
            StCsum: begin
                if (xfer) begin
                    done_d  = (in_data == sum_q);
                    err_d   = (in_data != sum_q);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stays high through the done/err pulse cycle.
        hold_d = (state_d != StIdle) || done_d || err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sum_q     <= 8'h00;
            addr_lo_q <= 8'h00;
            lo_q      <= 8'h00;
            ptr_q     <= '0;
            cnt_q     <= 16'h0000;
            pm_we_q   <= 1'b0;
            pm_addr_q <= '0;
            pm_din_q  <= 16'h0000;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            addr_lo_q <= addr_lo_d;
            lo_q      <= lo_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            pm_we_q   <= pm_we_d;
            pm_addr_q <= pm_addr_d;
            pm_din_q  <= pm_din_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign pm_we    = pm_we_q;
    assign pm_addr  = pm_addr_q;
    assign pm_din   = pm_din_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
